// File: rtl/prog_mem_server.sv
// ---------------------------------------------------------------------------
// prog_mem_server
//
// Program-memory responder for the 8-bit CPU control unit. Holds a
// DEPTH x DATA_W program image that an external loader fills byte by byte
// over a valid/ready port. The control unit's fetch logic reads it over a
// req/ready handshake, and each response appears one cycle after the
// request is accepted.
//
// Optional feature (compile-time macro PM_CHECKSUM_EN):
//   defined   - checksum is the running XOR of every byte written during the
//               current load. It is cleared at load_start and holds from
//               load_done until the next load_start.
//   undefined - checksum is tied to zero and no XOR logic is built.
//
// Ports:
//   clk_ctrl     in   clock, rising edge
//   rst_ctrl     in   asynchronous active-high reset (also clears memory)
//   load_start   in   pulse: begin a (re)load at address 0
//   load_valid   in   load byte present
//   load_data    in   load byte
//   load_end     in   pulse: terminate the load early
//   load_ready   out  a load byte is accepted this cycle
//   load_done    out  one-cycle pulse when a load completes
//   load_count   out  bytes written by the current/last load (0..DEPTH)
//   fetch_req    in   fetch request
//   fetch_addr   in   fetch address (PC)
//   fetch_ready  out  fetch request accepted this cycle
//   instr_valid  out  instr_data valid (one-cycle pulse)
//   instr_data   out  fetched word; holds its value between responses
//   fetch_err    out  sticky: a fetch_req arrived while fetch_ready was 0
//   checksum     out  load checksum (see optional feature)
// ---------------------------------------------------------------------------
module prog_mem_server #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk_ctrl,
    input  logic              rst_ctrl,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_end,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic              fetch_err,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Count value of the byte that fills the last word of the image.
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    state_t              state_q,      state_d;
    logic [ADDR_W-1:0]   wptr_q,       wptr_d;
    logic [ADDR_W:0]     load_count_q, load_count_d;
    logic                load_done_q,  load_done_d;
    logic [DATA_W-1:0]   instr_data_q, instr_data_d;
    logic                fetch_err_q,  fetch_err_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];

    // restart: (re)enter LOAD from address 0; byte_we: accept one load byte.
    logic restart;
    logic byte_we;

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        load_count_d = load_count_q;
        load_done_d  = 1'b0;
        instr_data_d = instr_data_q;
        fetch_err_d  = fetch_err_q;
        mem_d        = mem_q;
        load_ready   = 1'b0;
        fetch_ready  = 1'b0;
        instr_valid  = 1'b0;
        restart      = 1'b0;
        byte_we      = 1'b0;

        case (state_q)
            S_EMPTY: begin
                if (fetch_req) begin
                    fetch_err_d = 1'b1;
                end
                if (load_start) begin
                    restart = 1'b1;
                end
            end

            S_LOAD: begin
                load_ready = 1'b1;
                if (fetch_req) begin
                    fetch_err_d = 1'b1;
                end
                if (load_start) begin
                    restart = 1'b1;
                end else begin
                    byte_we = load_valid;
                    // A byte coincident with load_end is written before the exit.
                    if (load_end || (load_valid && (load_count_q == LAST_CNT))) begin
                        load_done_d = 1'b1;
                        state_d     = S_READY;
                    end
                end
            end

            S_READY: begin
                fetch_ready = 1'b1;
                if (load_start) begin
                    // Load has priority; a simultaneous fetch is dropped and flagged.
                    restart = 1'b1;
                    if (fetch_req) begin
                        fetch_err_d = 1'b1;
                    end
                end else if (fetch_req) begin
                    // Memory cannot change before the response, so capturing
                    // the word now is equivalent to latching the address.
                    instr_data_d = mem_q[fetch_addr];
                    state_d      = S_RESP;
                end
            end

            S_RESP: begin
                instr_valid = 1'b1;
                if (fetch_req) begin
                    fetch_err_d = 1'b1;
                end
                if (load_start) begin
                    restart = 1'b1;
                end else begin
                    state_d = S_READY;
                end
            end

            default: begin
                state_d = S_EMPTY;
            end
        endcase

        if (byte_we) begin
            mem_d[wptr_q] = load_data;
            wptr_d        = wptr_q + 1'b1;
            load_count_d  = load_count_q + 1'b1;
        end

        if (restart) begin
            state_d      = S_LOAD;
            wptr_d       = '0;
            load_count_d = '0;
        end
    end

    always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
        if (rst_ctrl) begin
            state_q      <= S_EMPTY;
            wptr_q       <= '0;
            load_count_q <= '0;
            load_done_q  <= 1'b0;
            instr_data_q <= '0;
            fetch_err_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            load_count_q <= load_count_d;
            load_done_q  <= load_done_d;
            instr_data_q <= instr_data_d;
            fetch_err_q  <= fetch_err_d;
            mem_q        <= mem_d;
        end
    end

`ifdef PM_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (restart) begin
            checksum_d = '0;
        end else if (byte_we) begin
            checksum_d = checksum_q ^ load_data;
        end
    end

    always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
        if (rst_ctrl) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign load_done  = load_done_q;
    assign load_count = load_count_q;
    assign instr_data = instr_data_q;
    assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_prog_mem_server.sv
// ---------------------------------------------------------------------------
// tb_prog_mem_server
//
// Directed testbench for prog_mem_server. Inputs change 1 ns after a rising
// edge, and outputs are sampled at that same point, i.e. after the edge that
// consumed the previous inputs. Expected checksum values follow
// PM_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_prog_mem_server;

    logic       clk_ctrl;
    logic       rst_ctrl;
    logic       load_start;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_end;
    logic       load_ready;
    logic       load_done;
    logic [4:0] load_count;
    logic       fetch_req;
    logic [3:0] fetch_addr;
    logic       fetch_ready;
    logic       instr_valid;
    logic [7:0] instr_data;
    logic       fetch_err;
    logic [7:0] checksum;

    int checks;
    int errors;

`ifdef PM_CHECKSUM_EN
    localparam logic [7:0] CS_ABC  = 8'hD0;  // A1 ^ B2 ^ C3
    localparam logic [7:0] CS_5566 = 8'h33;  // 55 ^ 66
`else
    localparam logic [7:0] CS_ABC  = 8'h00;
    localparam logic [7:0] CS_5566 = 8'h00;
`endif

    prog_mem_server #(
        .ADDR_W(4),
        .DATA_W(8),
        .DEPTH (16)
    ) dut (
        .clk_ctrl   (clk_ctrl),
        .rst_ctrl   (rst_ctrl),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_end   (load_end),
        .load_ready (load_ready),
        .load_done  (load_done),
        .load_count (load_count),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ready(fetch_ready),
        .instr_valid(instr_valid),
        .instr_data (instr_data),
        .fetch_err  (fetch_err),
        .checksum   (checksum)
    );

    initial clk_ctrl = 1'b0;
    always #5 clk_ctrl = ~clk_ctrl;

    task automatic tick();
        @(posedge clk_ctrl);
        #1;
    endtask

    task automatic do_reset();
        rst_ctrl = 1'b1;
        tick();
        rst_ctrl = 1'b0;
    endtask

    task automatic test_reset();
        rst_ctrl   = 1'b1;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        load_end   = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = 4'd0;
        tick();
        tick();
        checks++;
        if ({load_ready, load_done, load_count, fetch_ready, instr_valid, instr_data, fetch_err, checksum} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b done=%b cnt=%0d frdy=%b iv=%b id=%h err=%b cs=%h required all zero",
                     load_ready, load_done, load_count, fetch_ready, instr_valid, instr_data, fetch_err, checksum);
        end
        rst_ctrl = 1'b0;
        tick();
        checks++;
        if (load_ready !== 1'b0 || fetch_ready !== 1'b0) begin
            errors++;
            $display("FAIL empty_ready: got load_ready=%b fetch_ready=%b required 0 0", load_ready, fetch_ready);
        end
    endtask

    task automatic test_full_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        checks++;
        if (load_ready !== 1'b1 || load_count !== 5'd0) begin
            errors++;
            $display("FAIL full_entry: got load_ready=%b load_count=%0d required 1 0", load_ready, load_count);
        end
        for (int i = 0; i < 16; i++) begin
            load_valid = 1'b1;
            load_data  = 8'h10 + 8'(i);
            tick();
            if (i == 14) begin
                checks++;
                if (load_ready !== 1'b1 || load_count !== 5'd15 || load_done !== 1'b0) begin
                    errors++;
                    $display("FAIL full_15: got load_ready=%b count=%0d done=%b required 1 15 0",
                             load_ready, load_count, load_done);
                end
            end
        end
        load_valid = 1'b0;
        checks++;
        if (load_done !== 1'b1 || load_count !== 5'd16 || fetch_ready !== 1'b1 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_done: got done=%b count=%0d fetch_ready=%b load_ready=%b required 1 16 1 0",
                     load_done, load_count, fetch_ready, load_ready);
        end
        checks++;
        if (checksum !== 8'h00) begin
            errors++;
            $display("FAIL full_checksum: got %h required 00", checksum);
        end
        fetch_req  = 1'b1;
        fetch_addr = 4'd5;
        tick();
        fetch_req = 1'b0;
        checks++;
        if (load_done !== 1'b0) begin
            errors++;
            $display("FAIL full_done_pulse: got load_done=%b required 0", load_done);
        end
        checks++;
        if (instr_valid !== 1'b1 || instr_data !== 8'h15 || fetch_ready !== 1'b0) begin
            errors++;
            $display("FAIL fetch5: got valid=%b data=%h fetch_ready=%b required 1 15 0",
                     instr_valid, instr_data, fetch_ready);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0 || instr_data !== 8'h15 || fetch_err !== 1'b0 || fetch_ready !== 1'b1) begin
            errors++;
            $display("FAIL fetch5_after: got valid=%b data=%h err=%b fetch_ready=%b required 0 15 0 1",
                     instr_valid, instr_data, fetch_err, fetch_ready);
        end
    endtask

    task automatic test_load_end();
        logic [7:0] exp_word [4];
        exp_word[0] = 8'hA1;
        exp_word[1] = 8'hB2;
        exp_word[2] = 8'hC3;
        exp_word[3] = 8'h13;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        checks++;
        if (load_count !== 5'd0 || checksum !== 8'h00 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL reload_entry: got count=%0d cs=%h load_ready=%b required 0 00 1",
                     load_count, checksum, load_ready);
        end
        load_valid = 1'b1;
        load_data  = 8'hA1;
        tick();
        load_data = 8'hB2;
        tick();
        load_data = 8'hC3;
        load_end  = 1'b1;
        tick();
        load_valid = 1'b0;
        load_end   = 1'b0;
        checks++;
        if (load_done !== 1'b1 || load_count !== 5'd3 || fetch_ready !== 1'b1) begin
            errors++;
            $display("FAIL end_done: got done=%b count=%0d fetch_ready=%b required 1 3 1",
                     load_done, load_count, fetch_ready);
        end
        checks++;
        if (checksum !== CS_ABC) begin
            errors++;
            $display("FAIL end_checksum: got %h required %h", checksum, CS_ABC);
        end
        for (int a = 0; a < 4; a++) begin
            fetch_req  = 1'b1;
            fetch_addr = 4'(a);
            tick();
            fetch_req = 1'b0;
            checks++;
            if (instr_valid !== 1'b1 || instr_data !== exp_word[a]) begin
                errors++;
                $display("FAIL end_word%0d: got valid=%b data=%h required 1 %h",
                         a, instr_valid, instr_data, exp_word[a]);
            end
            tick();
        end
        checks++;
        if (checksum !== CS_ABC || load_count !== 5'd3) begin
            errors++;
            $display("FAIL end_stable: got cs=%h count=%0d required %h 3", checksum, load_count, CS_ABC);
        end
    endtask

    task automatic test_back_to_back();
        checks++;
        if (fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_err_before: got %b required 0", fetch_err);
        end
        fetch_req  = 1'b1;
        fetch_addr = 4'd0;
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_data !== 8'hA1) begin
            errors++;
            $display("FAIL b2b_0: got valid=%b data=%h required 1 a1", instr_valid, instr_data);
        end
        fetch_addr = 4'd1;
        tick();
        checks++;
        if (instr_valid !== 1'b0 || fetch_err !== 1'b1 || instr_data !== 8'hA1) begin
            errors++;
            $display("FAIL b2b_gap0: got valid=%b err=%b data=%h required 0 1 a1",
                     instr_valid, fetch_err, instr_data);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_data !== 8'hB2) begin
            errors++;
            $display("FAIL b2b_1: got valid=%b data=%h required 1 b2", instr_valid, instr_data);
        end
        fetch_addr = 4'd2;
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap1: got valid=%b required 0", instr_valid);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_data !== 8'hC3) begin
            errors++;
            $display("FAIL b2b_2: got valid=%b data=%h required 1 c3", instr_valid, instr_data);
        end
        // load_start during the response cycle enters LOAD on the next edge.
        fetch_req  = 1'b0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        checks++;
        if (load_ready !== 1'b1 || load_count !== 5'd0 || instr_valid !== 1'b0 || instr_data !== 8'hC3) begin
            errors++;
            $display("FAIL resp_load: got load_ready=%b count=%0d valid=%b data=%h required 1 0 0 c3",
                     load_ready, load_count, instr_valid, instr_data);
        end
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        checks++;
        if (load_done !== 1'b1 || load_count !== 5'd0 || fetch_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_load_done: got done=%b count=%0d fetch_ready=%b required 1 0 1",
                     load_done, load_count, fetch_ready);
        end
    endtask

    task automatic test_collision();
        do_reset();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_end   = 1'b1;
        tick();
        load_end = 1'b0;
        checks++;
        if (fetch_ready !== 1'b1 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL coll_pre: got fetch_ready=%b err=%b required 1 0", fetch_ready, fetch_err);
        end
        load_start = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 4'd5;
        tick();
        load_start = 1'b0;
        fetch_req  = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || fetch_err !== 1'b1 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL collision: got valid=%b err=%b load_ready=%b required 0 1 1",
                     instr_valid, fetch_err, load_ready);
        end
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
    endtask

    task automatic test_empty_fetch();
        do_reset();
        fetch_req  = 1'b1;
        fetch_addr = 4'd3;
        checks++;
        if (fetch_ready !== 1'b0 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL empty_pre: got fetch_ready=%b err=%b required 0 0", fetch_ready, fetch_err);
        end
        tick();
        fetch_req = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || fetch_err !== 1'b1) begin
            errors++;
            $display("FAIL empty_fetch: got valid=%b err=%b required 0 1", instr_valid, fetch_err);
        end
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_end   = 1'b1;
        tick();
        load_end   = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 4'd3;
        tick();
        fetch_req = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr_data !== 8'h00) begin
            errors++;
            $display("FAIL empty_word3: got valid=%b data=%h required 1 00", instr_valid, instr_data);
        end
        tick();
    endtask

    task automatic test_reset_mid_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'h55;
        tick();
        load_data = 8'h66;
        tick();
        load_valid = 1'b0;
        checks++;
        if (load_count !== 5'd2 || checksum !== CS_5566 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_load: got count=%0d cs=%h load_ready=%b required 2 %h 1",
                     load_count, checksum, load_ready, CS_5566);
        end
        #2;
        rst_ctrl = 1'b1;
        #1;
        checks++;
        if ({load_ready, load_done, load_count, fetch_ready, instr_valid, instr_data, fetch_err, checksum} !== 29'd0) begin
            errors++;
            $display("FAIL async_reset: got rdy=%b done=%b cnt=%0d frdy=%b iv=%b id=%h err=%b cs=%h required all zero",
                     load_ready, load_done, load_count, fetch_ready, instr_valid, instr_data, fetch_err, checksum);
        end
        tick();
        rst_ctrl   = 1'b0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_end   = 1'b1;
        tick();
        load_end   = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 4'd0;
        tick();
        fetch_req = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_word0: got valid=%b data=%h required 1 00", instr_valid, instr_data);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_full_load();
        test_load_end();
        test_back_to_back();
        test_collision();
        test_empty_fetch();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
